// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: synchroniser, mid-bit sampling, parity/stop checks, valid/ready buffer.
// Optional macro UART_RX_MAJORITY_EN selects a 3-sample majority vote instead of one centre sample.
package uart_pkg;
    typedef enum logic [1:0] {WL5 = 2'd0, WL6 = 2'd1, WL7 = 2'd2, WL8 = 2'd3} word_len_e;
    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic break_int;
    } rx_err_s;
endpackage

module uart_rx_ovs #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx,
    input  logic                div_clk_en,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [7:0]          rx_data,
    output uart_pkg::rx_err_s   rx_err,
    output logic                rx_overrun,
    input  uart_pkg::word_len_e cfg_word_len,
    input  logic                cfg_parity_en,
    input  logic                cfg_even_parity,
    input  logic                cfg_force_parity,
    input  logic                cfg_stop2
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   rx_s, fall;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          t_q, t_d;
    logic [2:0]             bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [7:0]             data_q, data_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   brk_q, brk_d;
    logic                   vld_q, vld_d;
    logic [7:0]             out_data_q, out_data_d;
    uart_pkg::rx_err_s      out_err_q, out_err_d;
    logic                   ovr_q, ovr_d;
    logic                   busy, dec_now, dec_bit;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = edge_q & ~rx_s;
    assign busy = (state_q != IDLE);
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign edge_d = rx_s;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] T_S0  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_S1  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_DEC = CW'(OVERSAMPLE / 2 + 1);
    logic smp0_q, smp0_d, smp1_q, smp1_d;

    always_comb begin
        smp0_d = smp0_q;
        smp1_d = smp1_q;
        if (busy && div_clk_en && t_q == T_S0) smp0_d = rx_s;
        if (busy && div_clk_en && t_q == T_S1) smp1_d = rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp0_q <= 1'b1;
            smp1_q <= 1'b1;
        end else begin
            smp0_q <= smp0_d;
            smp1_q <= smp1_d;
        end
    end

    assign dec_now = busy & div_clk_en & (t_q == T_DEC);
    assign dec_bit = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
`else
    localparam logic [CW-1:0] T_DEC = CW'(OVERSAMPLE / 2);
    assign dec_now = busy & div_clk_en & (t_q == T_DEC);
    assign dec_bit = rx_s;
`endif

    logic [2:0]        last_bit;
    logic              par_exp;
    logic              done;
    uart_pkg::rx_err_s new_err;

    assign last_bit = {1'b0, cfg_word_len} + 3'd4;

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        brk_d      = brk_q;
        vld_d      = vld_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        ovr_d      = 1'b0;
        done       = 1'b0;
        par_exp    = cfg_force_parity ? ~cfg_even_parity
                                      : (cfg_even_parity ? ^data_q : ~^data_q);
        new_err.parity_err = par_err_q;
        new_err.frame_err  = frm_err_q | ~dec_bit;
        new_err.break_int  = brk_q & ~dec_bit;

        if (!busy) begin
            t_d = '0;
            if (fall) state_d = START;
        end else if (div_clk_en) begin
            t_d = (t_q == T_LAST) ? '0 : t_q + 1'b1;
        end

        if (dec_now) begin
            case (state_q)
                START: begin
                    if (dec_bit) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_d     = '0;
                        stop_d    = 1'b0;
                        data_d    = '0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        brk_d     = 1'b1;
                    end
                end
                DATA: begin
                    data_d = data_q | ({7'd0, dec_bit} << bit_q);
                    brk_d  = brk_q & ~dec_bit;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == last_bit) state_d = cfg_parity_en ? PARITY : STOP;
                end
                PARITY: begin
                    par_err_d = (dec_bit != par_exp);
                    brk_d     = brk_q & ~dec_bit;
                    state_d   = STOP;
                end
                STOP: begin
                    frm_err_d = new_err.frame_err;
                    brk_d     = new_err.break_int;
                    if (cfg_stop2 && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A handshake in the completion cycle frees the buffer for the new frame.
        if (done) begin
            if (!vld_q || rx_ready) begin
                vld_d      = 1'b1;
                out_data_d = data_q;
                out_err_d  = new_err;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && rx_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            edge_q     <= 1'b1;
            state_q    <= IDLE;
            t_q        <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            brk_q      <= 1'b0;
            vld_q      <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            state_q    <= state_d;
            t_q        <= t_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            brk_q      <= brk_d;
            vld_q      <= vld_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_valid   = vld_q;
    assign rx_data    = out_data_q;
    assign rx_err     = out_err_q;
    assign rx_overrun = ovr_q;
endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised UART receiver, successor to the fixed 16x receiver in the UART subsystem. Adds a configurable oversampling ratio, an input synchroniser, 3-sample majority voting, optional second stop-bit checking, and a buffered valid/ready output with overrun detection. It sits between the pad-side serial input and the receive FIFO / register block, clocked by the system clock and enabled by the baud divider's tick.

## Interface
- `OVERSAMPLE`, 16: `div_clk_en` ticks per bit. Must be even, 8..256. Counter width is `$clog2(OVERSAMPLE)`.
- `SYNC_STAGES`, 2: synchroniser flops on `rx`. Range 2..4.
- `clk` input 1: system clock.
- `rst_n` input 1: reset; asynchronous, active-low.
- `rx` input 1: asynchronous serial input; idle high.
- `div_clk_en` input 1: one-cycle tick at `OVERSAMPLE` × baud.
- `rx_valid` output 1: output buffer holds a frame.
- `rx_ready` input 1: consumer accepts the frame when `rx_valid & rx_ready`.
- `rx_data` output 8: received word, LSB-aligned and zero-extended.
- `rx_err` output `uart_pkg::rx_err_s`: fields `parity_err`, `frame_err`, `break_int`, held with `rx_data`.
- `rx_overrun` output 1: one-cycle pulse when a completed frame is dropped.
- `cfg_word_len` input `uart_pkg::word_len_e`: 5..8 data bits.
- `cfg_parity_en` input 1: enables the parity bit.
- `cfg_even_parity` input 1: selects even parity.
- `cfg_force_parity` input 1: forces (stick) parity; the expected parity bit is `~cfg_even_parity`.
- `cfg_stop2` input 1: check two stop bits.
- Configuration inputs are static while not in IDLE.

## Operation
- **Synchroniser:** `rx` passes through `SYNC_STAGES` flops, each reset to 1, producing `rx_s`. The falling-edge detector is one further flop on `rx_s`.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge of `rx_s`. The bit-phase counter `t` is cleared to 0.
  - In every non-IDLE state, `t` increments on `div_clk_en` and wraps from `OVERSAMPLE-1` to 0.
- **Sampling:** let H = `OVERSAMPLE/2`.
  - Samples of `rx_s` are taken on ticks with t = H-1, H and H+1.
  - The bit decision is made on the tick with t = H+1. It is the majority of the three samples.
  - All state transitions occur only at a decision.
- **Transitions at each decision:**
  - START: decision 1 (false start) → IDLE, no output. Decision 0 → DATA.
  - DATA: shift the decision in LSB-first. After N bits (N = word length), go to PARITY if `cfg_parity_en`, else STOP.
  - PARITY: compute `parity_err`.
    - Normal mode: error when decision ≠ (`cfg_even_parity` ? XOR of data : ~XOR of data).
    - Force mode: error when decision ≠ `~cfg_even_parity`.
  - STOP:
    - Without `cfg_stop2`: the first stop decision completes the frame → IDLE.
    - With `cfg_stop2`: the second stop decision completes the frame → IDLE.
    - `frame_err` is set if any stop decision is 0.
- **Break:** `break_int` = 1 when every decision from the first data bit through the last stop bit is 0, including parity when enabled.
- **Completion:** the frame is written to the output buffer (`rx_data`, `rx_err`) when either:
  - `rx_valid` = 0, or
  - `rx_valid & rx_ready` in the same cycle (the simultaneous handshake and load is not an overrun).
  Otherwise the new frame is discarded, the buffer is unchanged, and `rx_overrun` pulses for 1 cycle.
- **Clearing:** `rx_valid` clears on a handshake with no simultaneous load.
- **Re-arm:** returning to IDLE mid-stop-bit allows immediate resynchronisation on the next start edge.

## Timing
- Reset values:
  - State IDLE, t = 0.
  - `rx_valid` = 0, `rx_data` = 0, all `rx_err` fields = 0, `rx_overrun` = 0.
  - Synchroniser and edge flops = 1.
- Edge-detect latency: `SYNC_STAGES`+1 `clk` cycles after `rx` falls.
- `rx_valid` rises 1 `clk` after the final stop decision tick. `rx_data` and `rx_err` are registered and stable while `rx_valid` = 1.
- `rx_overrun` is asserted in the same cycle `rx_valid` would have been loaded.
- `rst_n` asserted mid-frame aborts the frame immediately. No output is produced after release until a new falling edge.
- A `div_clk_en` held high continuously is legal: 1 tick per `clk`.

## Configuration
- `UART_RX_MAJORITY_EN`
  - Defined: 3-sample majority vote as above.
  - Undefined: single sample at t = H. The decision (and all transitions) move to the tick with t = H, and the sample registers are removed.
  - All other behaviour is identical.

## Test plan
- **8N1, OVERSAMPLE = 16:** send 0xA5 → `rx_valid` with `rx_data` = 0xA5 and all errors 0. `rx_valid` is held until `rx_ready`.
- **7E2, force off:** send 0x35 with parity bit 1 → `parity_err` = 1. Then send a frame with the second stop bit = 0 → `frame_err` = 1, `parity_err` = 0.
- **Break:** hold `rx` low for 12 bit times in 8N1 → one frame with `rx_data` = 0x00, `frame_err` = 1, `break_int` = 1.
- **Glitch:** a 1-tick low glitch on the start bit → IDLE, no `rx_valid`. With `UART_RX_MAJORITY_EN`, a 1-tick spike inside a data bit is rejected (0x5A received intact).
- **Overrun:** two back-to-back 0x11 and 0x22 frames with `rx_ready` = 0 → `rx_data` stays 0x11 and `rx_overrun` pulses once. Repeat with `rx_ready` = 1 in the completion cycle → 0x22 loaded, no pulse.
- **OVERSAMPLE = 8, 5O1, and reset mid-DATA** → correct 0x1B reception. After reset release, no spurious `rx_valid`.
